// File: rtl/uart_tx_fifo_if.sv
// Write/status bundle between the memory-mapped UART strobe logic and the TX block.
interface uart_tx_fifo_if #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned LW        = 5
);
   logic                 wr_en;
   logic [DATA_BITS-1:0] wr_data;
   logic                 clr_ovf;
   logic                 full;
   logic                 empty;
   logic [LW-1:0]        level;
   logic                 overflow;
   logic                 busy;
   logic                 TXD;

   modport master (
      output wr_en, wr_data, clr_ovf,
      input  full, empty, level, overflow, busy, TXD
   );

   modport slave (
      input  wr_en, wr_data, clr_ovf,
      output full, empty, level, overflow, busy, TXD
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with TX FIFO, configurable framing and polled status flags.
module uart_tx_fifo #(
   parameter int unsigned DIVISOR    = 868,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned LW         = $clog2(FIFO_DEPTH) + 1
) (
   input logic           CLK,
   input logic           RST,
   uart_tx_fifo_if.slave bus
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(DIVISOR);
   localparam int unsigned BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] BAUD_RELOAD = CW'(DIVISOR - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wptr_q;
   logic [AW-1:0]        rptr_q;
   logic [LW-1:0]        level_q;
   logic [LW-1:0]        level_d;
   logic                 full_q;
   logic                 empty_q;
   logic                 ovf_q;
   logic                 ovf_d;
   logic                 busy_q;
   logic                 busy_d;

   state_e               state_q;
   logic [CW-1:0]        baud_q;
   logic [BW-1:0]        bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_q;
   logic                 txd_q;

   logic                 push_c;
   logic                 pop_c;
   logic                 bit_end_c;
   logic                 stop_last_c;
   logic                 idle_next_c;
   logic [DATA_BITS-1:0] head_c;
   logic                 head_par_c;

   // Handshake decode; full/empty are the registered values from the start of the cycle.
   always_comb begin
      push_c      = bus.wr_en && !full_q;
      bit_end_c   = (baud_q == '0);
      stop_last_c = (state_q == S_STOP) && bit_end_c && (bit_q == BW'(STOP_BITS - 1));
      pop_c       = ((state_q == S_IDLE) || stop_last_c) && !empty_q;
      idle_next_c = !pop_c && ((state_q == S_IDLE) || stop_last_c);
      head_c      = mem_q[rptr_q];
      head_par_c  = (^head_c) ^ (PARITY == 1);

      level_d = level_q;
      if (push_c && !pop_c) begin
         level_d = level_q + LW'(1);
      end else if (!push_c && pop_c) begin
         level_d = level_q - LW'(1);
      end

      // A dropped write outranks a clear in the same cycle.
      ovf_d = ovf_q;
      if (bus.wr_en && full_q) begin
         ovf_d = 1'b1;
      end else if (bus.clr_ovf) begin
         ovf_d = 1'b0;
      end

      busy_d = !idle_next_c || (level_d != '0);
   end

   // Storage array carries no reset; validity is tracked by the pointers and level.
   always_ff @(posedge CLK) begin
      if (push_c) begin
         mem_q[wptr_q] <= bus.wr_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         if (push_c) begin
            wptr_q <= wptr_q + AW'(1);
         end
         if (pop_c) begin
            rptr_q <= rptr_q + AW'(1);
         end
         level_q <= level_d;
         full_q  <= (level_d == LW'(FIFO_DEPTH));
         empty_q <= (level_d == '0);
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
      end
   end

   // Frame sequencer; TXD is updated only on bit boundaries from a register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
      end else begin
         if (state_q != S_IDLE) begin
            baud_q <= bit_end_c ? BAUD_RELOAD : baud_q - CW'(1);
         end
         case (state_q)
            S_IDLE: begin
               if (pop_c) begin
                  state_q <= S_START;
                  baud_q  <= BAUD_RELOAD;
                  shift_q <= head_c;
                  par_q   <= head_par_c;
                  txd_q   <= 1'b0;
               end
            end
            S_START: begin
               if (bit_end_c) begin
                  state_q <= S_DATA;
                  bit_q   <= '0;
                  txd_q   <= shift_q[0];
                  shift_q <= shift_q >> 1;
               end
            end
            S_DATA: begin
               if (bit_end_c) begin
                  if (bit_q == BW'(DATA_BITS - 1)) begin
                     bit_q <= '0;
                     if (PARITY != 0) begin
                        state_q <= S_PARITY;
                        txd_q   <= par_q;
                     end else begin
                        state_q <= S_STOP;
                        txd_q   <= 1'b1;
                     end
                  end else begin
                     bit_q   <= bit_q + BW'(1);
                     txd_q   <= shift_q[0];
                     shift_q <= shift_q >> 1;
                  end
               end
            end
            S_PARITY: begin
               if (bit_end_c) begin
                  state_q <= S_STOP;
                  txd_q   <= 1'b1;
               end
            end
            S_STOP: begin
               if (bit_end_c) begin
                  if (bit_q == BW'(STOP_BITS - 1)) begin
                     bit_q <= '0;
                     // Chain straight into the next start bit when data is waiting.
                     if (pop_c) begin
                        state_q <= S_START;
                        shift_q <= head_c;
                        par_q   <= head_par_c;
                        txd_q   <= 1'b0;
                     end else begin
                        state_q <= S_IDLE;
                        baud_q  <= '0;
                     end
                  end else begin
                     bit_q <= bit_q + BW'(1);
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               txd_q   <= 1'b1;
            end
         endcase
      end
   end

   assign bus.full     = full_q;
   assign bus.empty    = empty_q;
   assign bus.level    = level_q;
   assign bus.overflow = ovf_q;
   assign bus.busy     = busy_q;
   assign bus.TXD      = txd_q;
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised successor to the core's single-byte UART transmit controller.
- Adds a configurable TX FIFO, a run-time-free baud divisor parameter, and selectable data bits, parity and stop bits.
- Adds status outputs (full, empty, level, busy) and a sticky overflow flag so firmware can poll before storing.
- Sits between the RAM's memory-mapped UART strobe/data and the TXD pin.

Parameters:
- DIVISOR, 868: clock cycles per bit (100 MHz / 115200); legal range is at least 2.
- DATA_BITS, 8: data bits per frame; legal values 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: entries; a power of 2, at least 2.
- LW, $clog2(FIFO_DEPTH)+1: width of the level output.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe; one entry per asserted cycle.
- wr_data  in  DATA_BITS  byte to enqueue.
- clr_ovf  in  1  clears the overflow flag.
- full  out  1  level == FIFO_DEPTH (registered).
- empty  out  1  level == 0 (registered).
- level  out  LW  current FIFO occupancy.
- overflow  out  1  sticky; set when a write was dropped.
- busy  out  1  state != IDLE or !empty.
- TXD  out  1  serial line, idles high.

Behaviour:
- Reset (synchronous, active-high):
  - TXD=1, full=0, empty=1, level=0, overflow=0, busy=0.
  - Pointers, baud counter, bit counter and shift register are zeroed; state=IDLE.
  - RST mid-frame aborts the frame: TXD=1 on the next cycle and FIFO contents are discarded.
- FIFO write:
  - Accepted when wr_en=1 and full=0 (value at start of cycle).
  - wr_en with full=1 drops the data, leaves level unchanged, and sets overflow next cycle.
  - A pop in the same cycle does not rescue a write rejected on full.
- Pop:
  - Occurs in any cycle where state is IDLE or at end of the final stop bit, and empty=0.
  - The head entry loads the shift register and state becomes START.
  - Simultaneous write and pop leaves level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow: clr_ovf clears it. If set and clear occur in the same cycle, set wins.
- FSM: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE, or STOP -> START if non-empty.
  - Each state holds for exactly DIVISOR cycles per bit; the baud counter reloads to DIVISOR-1 on entry to each bit.
  - START drives TXD=0.
  - DATA drives LSB first over DATA_BITS bits.
  - PARITY: even drives XOR of the data; odd drives its inverse.
  - STOP drives TXD=1 for STOP_BITS*DIVISOR cycles.
- Latency:
  - A write at cycle N into an empty FIFO with the FSM IDLE gives level=1 and the pop at N+1, and TXD=0 from N+2.
  - Back-to-back frames have no idle gap: the next start bit begins the cycle after the last stop cycle.
- TXD is driven from a register (glitch-free).
- Frame length is (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIVISOR cycles.

Test Plan:
- Config DIVISOR=4, defaults otherwise. Write 0x55 at cycle 0 -> TXD low for cycles 2-5, then 1,0,1,0,1,0,1,0 at 4 cycles each (cycles 6-37), high for 38-41; busy=0 from cycle 42.
- Write 0xA5 at cycle 0 and 0x3C at cycle 1 -> second start bit begins at cycle 42 with no high gap; decoded bytes are 0xA5 then 0x3C.
- Config FIFO_DEPTH=4, DIVISOR=4. Write 6 bytes on cycles 0-5 -> level reaches 4 and full=1 at cycle 5; 6th byte dropped; overflow=1 at cycle 6. Exactly 5 frames are transmitted, then empty=1 and busy=0.
- PARITY=2 with 0x07 -> parity bit 1. PARITY=1 with 0x07 -> parity bit 0. With STOP_BITS=2, the stop period is 8 cycles.
- Assert RST for one cycle during the 3rd data bit with 2 bytes queued -> TXD=1 next cycle, level=0, empty=1; no further frames after release.
- Overflow set: clr_ovf asserted in the same cycle as a dropped write -> overflow stays 1. clr_ovf alone on a later cycle -> overflow=0 next cycle.
